slt_sltu_serial_ctrl: RTL

Multi-cycle set-less-than unit for area-constrained RISC-V cores, supporting both signed (slt) and unsigned (sltu) compares. It time-shares one SLICE_WIDTH-bit ripple-borrow subtractor slice across the operand. The slice is built from full_subtractor cells, and the design instantiates it once rather than DATA_WIDTH/SLICE_WIDTH times. The block processes operands LSB slice first with a registered borrow chain, then applies the sign/borrow select to produce the slt/sltu bit. It sits between the decode/issue stage and the writeback path, using valid/ready handshakes on both sides.

---
 rtl/slt_sltu_serial_ctrl.sv | 150 +++++++++++++++
 1 files changed

// File: rtl/slt_sltu_serial_ctrl.sv
// Serial slt/sltu unit: one SLICE_WIDTH-bit ripple-borrow slice walks the operands LSB first.
// Optional SLT_SERIAL_EQ_FLAG_EN adds an O_EQUAL output (A == B) registered with the result.

module full_subtractor (
   input  logic a,
   input  logic b,
   input  logic bi,
   output logic d,
   output logic bo
);
   assign d  = a ^ b ^ bi;
   assign bo = (~a & b) | (~(a ^ b) & bi);
endmodule

module slt_sltu_serial_ctrl #(
   parameter int DATA_WIDTH  = 32,
   parameter int SLICE_WIDTH = 4
) (
   input  logic                  I_CLK,
   input  logic                  I_RST,
   input  logic                  I_VALID,
   output logic                  O_READY,
   input  logic [DATA_WIDTH-1:0] I_OP_A,
   input  logic [DATA_WIDTH-1:0] I_OP_B,
   input  logic                  I_U,
   output logic                  O_VALID,
   input  logic                  I_READY,
   output logic                  O_RESULT,
`ifdef SLT_SERIAL_EQ_FLAG_EN
   output logic                  O_EQUAL,
`endif
   output logic                  O_BUSY
);
   localparam int N  = DATA_WIDTH / SLICE_WIDTH;
   localparam int CW = (N > 1) ? $clog2(N) : 1;
   localparam logic [CW-1:0] LAST = CW'(N - 1);

   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_RUN  = 2'd1;
   localparam logic [1:0] S_DONE = 2'd2;

   if (DATA_WIDTH % SLICE_WIDTH != 0) begin : g_bad_width
      $error("DATA_WIDTH must be an integer multiple of SLICE_WIDTH");
   end

   logic [1:0]             state;
   logic [CW-1:0]          cnt;
   logic                   borrow;
   logic [DATA_WIDTH-1:0]  op_a, op_b, a_next;
   logic                   u_q, sign_a, sign_b;
   logic                   res_q, vld_q;
   logic [SLICE_WIDTH:0]   bchain;
   logic [SLICE_WIDTH-1:0] diff;
   logic                   res_next;

   assign bchain[0] = borrow;

   for (genvar i = 0; i < SLICE_WIDTH; i++) begin : g_fs
      full_subtractor u_fs (
         .a  (op_a[i]),
         .b  (op_b[i]),
         .bi (bchain[i]),
         .d  (diff[i]),
         .bo (bchain[i+1])
      );
   end

   // Difference bits rotate into A's vacated top slice, so A ends up holding A-B.
   if (N > 1) begin : g_rot
      assign a_next = {diff, op_a[DATA_WIDTH-1:SLICE_WIDTH]};
   end else begin : g_rot1
      assign a_next = diff;
   end

   // Differing signs decide a signed compare outright; otherwise the borrow does.
   assign res_next = (u_q || (sign_a == sign_b)) ? bchain[SLICE_WIDTH] : sign_a;

`ifdef SLT_SERIAL_EQ_FLAG_EN
   logic zero_acc, eq_q;
   assign O_EQUAL = eq_q;
`endif

   always_ff @(posedge I_CLK) begin
      if (I_RST) begin
         state  <= S_IDLE;
         cnt    <= '0;
         borrow <= 1'b0;
         op_a   <= '0;
         op_b   <= '0;
         u_q    <= 1'b0;
         sign_a <= 1'b0;
         sign_b <= 1'b0;
         res_q  <= 1'b0;
         vld_q  <= 1'b0;
`ifdef SLT_SERIAL_EQ_FLAG_EN
         zero_acc <= 1'b0;
         eq_q     <= 1'b0;
`endif
      end else begin
         case (state)
            S_IDLE: if (I_VALID) begin
               op_a   <= I_OP_A;
               op_b   <= I_OP_B;
               u_q    <= I_U;
               sign_a <= I_OP_A[DATA_WIDTH-1];
               sign_b <= I_OP_B[DATA_WIDTH-1];
               borrow <= 1'b0;
               cnt    <= '0;
`ifdef SLT_SERIAL_EQ_FLAG_EN
               zero_acc <= 1'b1;
`endif
               state  <= S_RUN;
            end
            S_RUN: begin
               op_a   <= a_next;
               op_b   <= op_b >> SLICE_WIDTH;
               borrow <= bchain[SLICE_WIDTH];
`ifdef SLT_SERIAL_EQ_FLAG_EN
               zero_acc <= zero_acc & (diff == '0);
`endif
               if (cnt == LAST) begin
                  res_q <= res_next;
`ifdef SLT_SERIAL_EQ_FLAG_EN
                  eq_q  <= zero_acc & (diff == '0);
`endif
                  state <= S_DONE;
               end else begin
                  cnt <= cnt + CW'(1);
               end
            end
            // Valid rises one edge after DONE entry; the handshake completes on it.
            S_DONE: begin
               if (!vld_q) begin
                  vld_q <= 1'b1;
               end else if (I_READY) begin
                  vld_q <= 1'b0;
                  state <= S_IDLE;
               end
            end
            default: state <= S_IDLE;
         endcase
      end
   end

   assign O_READY  = (state == S_IDLE);
   assign O_BUSY   = (state != S_IDLE);
   assign O_VALID  = vld_q;
   assign O_RESULT = res_q;

endmodule
